// File: rtl/alu_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : alu_sequencer_if
//  Description : Bundle of the instruction handshake, the registered ALU
//                operand/select bus, the ALU result return path, the
//                retirement status outputs and the debug register-file port.
//                The master modport is the sequencer itself; the slave
//                modport is its environment (instruction source plus the
//                combinational ALU).
//  Signals     : instr_valid/instr/instr_ready - instruction handshake
//                alu_a/alu_b/alu_sel            - operands and select to ALU
//                alu_result/alu_zero            - ALU outputs back in
//                done/err                       - one-cycle retire pulses
//                result/zero_flag               - last write-back status
//                dbg_addr/dbg_data              - debug register-file read
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface alu_sequencer_if;
    logic        instr_valid;
    logic [12:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_result;
    logic        alu_zero;
    logic        done;
    logic        err;
    logic [3:0]  result;
    logic        zero_flag;
    logic [1:0]  dbg_addr;
    logic [3:0]  dbg_data;

    modport master (
        input  instr_valid, instr, alu_result, alu_zero, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_sel, done, err,
               result, zero_flag, dbg_data
    );

    modport slave (
        output instr_valid, instr, alu_result, alu_zero, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_sel, done, err,
               result, zero_flag, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : alu_sequencer
//  Description : Multicycle issue controller for an external 4-bit
//                combinational ALU. Accepts one instruction per handshake in
//                IDLE, presents registered operands/select during EXEC,
//                writes the ALU result (or LDI immediate) back into a
//                4 x 4-bit register file at the end of EXEC, and pulses
//                done (plus err for illegal opcodes) in DONE.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - alu_sequencer_if master modport (handshake, ALU bus,
//                       status and debug read)
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module alu_sequencer (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_sequencer_if.master     bus
);

    // FSM encoding
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    // Opcodes that need special handling; 000..100 go straight to the ALU
    localparam logic [2:0] c_OP_SHIFT = 3'b100;
    localparam logic [2:0] c_OP_LDI   = 3'b101;
    localparam logic [2:0] c_SEL_NOP  = 3'b000;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic       w_ready;
    logic       w_done;
    logic       w_err;
    logic       w_accept;

    // Fields of the incoming instruction
    logic [2:0] w_in_op;
    logic [1:0] w_in_rd;
    logic [1:0] w_in_rs;
    logic [1:0] w_in_rt;
    logic [3:0] w_in_imm;
    logic       w_in_is_alu;

    // Latched instruction fields; source indices are consumed at accept
    logic [2:0] r_op;
    logic [1:0] r_rd;
    logic [3:0] r_imm;
    logic       w_op_is_alu;
    logic       w_op_is_ldi;
    logic       w_op_illegal;

    logic [3:0] r_rf [0:3];
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_sel;
    logic [3:0] r_result;
    logic       r_zero_flag;

    assign w_in_op  = bus.instr[12:10];
    assign w_in_rd  = bus.instr[9:8];
    assign w_in_rs  = bus.instr[7:6];
    assign w_in_rt  = bus.instr[5:4];
    assign w_in_imm = bus.instr[3:0];

    // ADD, SUB, AND, XOR and SHIFT occupy 000..100
    assign w_in_is_alu  = (w_in_op <= c_OP_SHIFT);
    assign w_op_is_alu  = (r_op <= c_OP_SHIFT);
    assign w_op_is_ldi  = (r_op == c_OP_LDI);
    assign w_op_illegal = r_op[2] & r_op[1];

    assign w_accept = bus.instr_valid & w_ready;

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next state and control outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_state_next = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                w_state_next = c_S_DONE;
            end
            c_S_DONE: begin
                w_done       = 1'b1;
                w_err        = w_op_illegal;
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Instruction latch, operand registers and write-back
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= 3'b000;
            r_rd        <= 2'd0;
            r_imm       <= 4'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_sel   <= c_SEL_NOP;
            r_result    <= 4'd0;
            r_zero_flag <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= 4'd0;
            end
        end else begin
            if (w_accept) begin
                r_op    <= w_in_op;
                r_rd    <= w_in_rd;
                r_imm   <= w_in_imm;
                // Sources are read here, so rd==rs/rt sees the old value
                r_alu_a <= r_rf[w_in_rs];
                r_alu_b <= r_rf[w_in_rt];
                // Only real ALU ops drive a meaningful select
                r_alu_sel <= w_in_is_alu ? w_in_op : c_SEL_NOP;
            end

            // Write-back on the edge that leaves EXEC; illegal ops skip it
            if (r_state == c_S_EXEC) begin
                if (w_op_is_alu) begin
                    r_rf[r_rd]  <= bus.alu_result;
                    r_result    <= bus.alu_result;
                    r_zero_flag <= bus.alu_zero;
                end else if (w_op_is_ldi) begin
                    r_rf[r_rd]  <= r_imm;
                    r_result    <= r_imm;
                    r_zero_flag <= (r_imm == 4'd0);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.instr_ready = w_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_sel     = r_alu_sel;
    assign bus.done        = w_done;
    assign bus.err         = w_err;
    assign bus.result      = r_result;
    assign bus.zero_flag   = r_zero_flag;
    assign bus.dbg_data    = r_rf[bus.dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_alu_sequencer
//  Description : Directed self-checking bench for alu_sequencer. Provides a
//                combinational 4-bit ALU on the interface and walks through
//                LDI/ALU sequences, shifts, an illegal opcode, held
//                instr_valid and a reset during EXEC.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    alu_sequencer_if bus ();

    alu_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (bus.alu_sel)
            3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_result = bus.alu_a ^ bus.alu_b;
            3'b100: begin
                case (bus.alu_b[1:0])
                    2'b00:   bus.alu_result = bus.alu_a;
                    2'b10:   bus.alu_result = {1'b0, bus.alu_a[3:1]};
                    default: bus.alu_result = {bus.alu_a[2:0], 1'b0};
                endcase
            end
            default: bus.alu_result = 4'd0;
        endcase
        bus.alu_zero = (bus.alu_result == 4'd0);
    end

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_SHF = 3'b100;
    localparam logic [2:0] c_LDI = 3'b101;
    localparam logic [2:0] c_ILL = 3'b110;

    function automatic logic [12:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt,
                                       input logic [3:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        bus.dbg_addr = idx;
        #1;
        chk(tag, {12'd0, bus.dbg_data}, {12'd0, exp});
    endtask

    // Present an instruction in IDLE; returns one cycle later, inside EXEC
    task automatic accept(input logic [12:0] ins);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        chk("exec_ready", {15'd0, bus.instr_ready}, 16'd0);
        chk("exec_done",  {15'd0, bus.done}, 16'd0);
    endtask

    // From EXEC, walk through DONE back to IDLE
    task automatic retire(input string tag, input logic exp_err);
        step();
        chk({tag, "_done"},  {15'd0, bus.done}, 16'd1);
        chk({tag, "_err"},   {15'd0, bus.err}, {15'd0, exp_err});
        chk({tag, "_rdy_n"}, {15'd0, bus.instr_ready}, 16'd0);
        step();
        chk({tag, "_rdy"},   {15'd0, bus.instr_ready}, 16'd1);
        chk({tag, "_done0"}, {15'd0, bus.done}, 16'd0);
    endtask

    task automatic run(input logic [12:0] ins, input string tag, input logic exp_err);
        accept(ins);
        retire(tag, exp_err);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 13'd0;
        bus.dbg_addr    = 2'd0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_ready", {15'd0, bus.instr_ready}, 16'd1);
        chk("rst_a",     {12'd0, bus.alu_a}, 16'd0);
        chk("rst_b",     {12'd0, bus.alu_b}, 16'd0);
        chk("rst_sel",   {13'd0, bus.alu_sel}, 16'd0);
        chk("rst_done",  {15'd0, bus.done}, 16'd0);
        chk("rst_err",   {15'd0, bus.err}, 16'd0);
        chk("rst_res",   {12'd0, bus.result}, 16'd0);
        chk("rst_zf",    {15'd0, bus.zero_flag}, 16'd0);
        for (int i = 0; i < 4; i++) chk_rf("rst_rf", 2'(i), 4'd0);

        // LDI r1,4; LDI r2,3; ADD r3,r1,r2
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h4), "ldi1", 1'b0);
        chk("ldi1_res", {12'd0, bus.result}, 16'h4);
        run(mk(c_LDI, 2'd2, 2'd0, 2'd0, 4'h3), "ldi2", 1'b0);
        accept(mk(c_ADD, 2'd3, 2'd1, 2'd2, 4'h0));
        chk("add_sel", {13'd0, bus.alu_sel}, 16'd0);
        chk("add_a",   {12'd0, bus.alu_a}, 16'h4);
        chk("add_b",   {12'd0, bus.alu_b}, 16'h3);
        retire("add", 1'b0);
        chk("add_res", {12'd0, bus.result}, 16'h7);
        chk("add_zf",  {15'd0, bus.zero_flag}, 16'd0);
        chk_rf("add_rf3", 2'd3, 4'h7);

        // Wrap-around to zero, then borrow
        run(mk(c_LDI, 2'd0, 2'd0, 2'd0, 4'hF), "ldiF", 1'b0);
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h1), "ldi1b", 1'b0);
        run(mk(c_ADD, 2'd2, 2'd0, 2'd1, 4'h0), "addw", 1'b0);
        chk("addw_res", {12'd0, bus.result}, 16'h0);
        chk("addw_zf",  {15'd0, bus.zero_flag}, 16'd1);
        accept(mk(c_SUB, 2'd3, 2'd1, 2'd0, 4'h0));
        chk("sub_sel", {13'd0, bus.alu_sel}, 16'd1);
        retire("sub", 1'b0);
        chk("sub_res", {12'd0, bus.result}, 16'h2);
        chk("sub_zf",  {15'd0, bus.zero_flag}, 16'd0);
        chk_rf("sub_rf3", 2'd3, 4'h2);

        // Shifts of 1001 by amounts 0..3 -> 9, 2, 4, 2
        run(mk(c_LDI, 2'd0, 2'd0, 2'd0, 4'h9), "ldi9", 1'b0);
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h0), "amt0", 1'b0);
        run(mk(c_SHF, 2'd2, 2'd0, 2'd1, 4'h0), "shf0", 1'b0);
        chk("shf0_res", {12'd0, bus.result}, 16'h9);
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h1), "amt1", 1'b0);
        run(mk(c_SHF, 2'd2, 2'd0, 2'd1, 4'h0), "shf1", 1'b0);
        chk("shf1_res", {12'd0, bus.result}, 16'h2);
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h2), "amt2", 1'b0);
        run(mk(c_SHF, 2'd2, 2'd0, 2'd1, 4'h0), "shf2", 1'b0);
        chk("shf2_res", {12'd0, bus.result}, 16'h4);
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h3), "amt3", 1'b0);
        run(mk(c_SHF, 2'd2, 2'd0, 2'd1, 4'h0), "shf3", 1'b0);
        chk("shf3_res", {12'd0, bus.result}, 16'h2);
        chk_rf("shf3_rf2", 2'd2, 4'h2);

        // ADD to 7, then an illegal opcode targeting r3
        run(mk(c_LDI, 2'd1, 2'd0, 2'd0, 4'h4), "ldi4", 1'b0);
        run(mk(c_LDI, 2'd2, 2'd0, 2'd0, 4'h3), "ldi3", 1'b0);
        run(mk(c_ADD, 2'd3, 2'd1, 2'd2, 4'h0), "add7", 1'b0);
        chk("add7_res", {12'd0, bus.result}, 16'h7);
        accept(mk(c_ILL, 2'd3, 2'd1, 2'd2, 4'h5));
        chk("ill_sel", {13'd0, bus.alu_sel}, 16'd0);
        retire("ill", 1'b1);
        chk("ill_res", {12'd0, bus.result}, 16'h7);
        chk("ill_zf",  {15'd0, bus.zero_flag}, 16'd0);
        chk_rf("ill_rf3", 2'd3, 4'h7);

        // instr_valid held high across EXEC/DONE with changing instr
        bus.instr       = mk(c_LDI, 2'd0, 2'd0, 2'd0, 4'h5);
        bus.instr_valid = 1'b1;
        step();                                   // accepted: now EXEC (N+1)
        bus.instr = mk(c_LDI, 2'd0, 2'd0, 2'd0, 4'hA);
        chk("hold_rdy1", {15'd0, bus.instr_ready}, 16'd0);
        step();                                   // DONE (N+2)
        chk("hold_rdy2", {15'd0, bus.instr_ready}, 16'd0);
        chk("hold_done", {15'd0, bus.done}, 16'd1);
        chk_rf("hold_rf0a", 2'd0, 4'h5);
        step();                                   // IDLE (N+3), accepts second
        chk("hold_rdy3", {15'd0, bus.instr_ready}, 16'd1);
        step();                                   // EXEC of second
        bus.instr_valid = 1'b0;
        chk("hold_exec2", {15'd0, bus.instr_ready}, 16'd0);
        chk_rf("hold_rf0b", 2'd0, 4'h5);
        retire("hold2", 1'b0);
        chk_rf("hold_rf0c", 2'd0, 4'hA);

        // Reset pulse during EXEC of ADD r3,r1,r2 (r3 currently 7)
        accept(mk(c_ADD, 2'd3, 2'd1, 2'd2, 4'h0));
        rst = 1'b1;
        #1;
        chk("mrst_done", {15'd0, bus.done}, 16'd0);
        chk("mrst_rdy",  {15'd0, bus.instr_ready}, 16'd1);
        step();
        rst = 1'b0;
        step();
        chk("mrst_done2", {15'd0, bus.done}, 16'd0);
        chk("mrst_err",   {15'd0, bus.err}, 16'd0);
        chk("mrst_rdy2",  {15'd0, bus.instr_ready}, 16'd1);
        chk("mrst_res",   {12'd0, bus.result}, 16'h0);
        chk("mrst_a",     {12'd0, bus.alu_a}, 16'h0);
        chk_rf("mrst_rf3", 2'd3, 4'h0);
        chk_rf("mrst_rf1", 2'd1, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
